pdm_duty_feeder: RTL and testbench
==================================

PDM_DUTY_FEEDER -- requirements
Module: pdm_duty_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter SAMPLE_DIV, default 1024, clk cycles per duty update (>=4).
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port smpl_in  input  16  signed two's-complement audio sample from the FIR filter.
REQ-006 SHALL have port smpl_vld  input  1  smpl_in valid.
REQ-007 SHALL have port smpl_rdy  output  1  feeder can accept a sample.
REQ-008 SHALL have port volume  input  8  unsigned gain, 0 = mute, 255 = 255/256.
REQ-009 SHALL have port clr_underrun  input  1  clears the underrun flag.
REQ-010 SHALL have port duty  output  16  unsigned offset-binary duty to the PDM modulator.
REQ-011 SHALL have port duty_upd  output  1  one-cycle pulse in the cycle duty takes a new value.
REQ-012 SHALL have port underrun  output  1  sticky flag, update tick found FIFO empty.

Function
REQ-013 SHALL push smpl_in into the FIFO on any rising edge where smpl_vld and smpl_rdy are both 1.
REQ-014 SHALL drive smpl_rdy = 1 exactly when the FIFO holds fewer than DEPTH entries and rst_n is 1.
REQ-015 SHALL run a divider counter 0..SAMPLE_DIV-1 that wraps to 0; "tick" = cycle in which counter == SAMPLE_DIV-1.
REQ-016 SHALL, on tick with FIFO non-empty, pop the head entry (cycle T).
REQ-017 SHALL register in cycle T+1 the scaled value = (head * {1'b0,volume}) arithmetic-shifted right 8, kept as signed 16 bits (24-bit signed product, no overflow).
REQ-018 SHALL sample volume in the same cycle as the pop (T).
REQ-019 SHALL load duty = scaled XOR 16'h8000 at cycle T+2 and assert duty_upd for exactly that cycle.
REQ-020 SHALL hold duty unchanged between updates.
REQ-021 SHALL, on tick with FIFO empty, leave duty unchanged, emit no duty_upd, and set underrun.
REQ-022 SHALL evaluate empty at a tick using the pre-edge occupancy: a push in the same cycle is stored but does not prevent underrun.
REQ-023 SHALL allow a push and a pop in the same cycle when 0 < occupancy < DEPTH; occupancy stays unchanged.
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH without data loss or duplication.
REQ-025 SHALL clear underrun on clr_underrun = 1; a simultaneous new underrun event SHALL win (flag stays 1).
REQ-026 SHALL keep the divider free-running regardless of FIFO state, volume or handshake activity.

Reset
REQ-027 SHALL, while rst_n = 0: duty = 16'h8000 (mid-scale/silence), duty_upd = 0, underrun = 0, smpl_rdy = 0, FIFO empty, divider = 0, pipeline registers cleared.
REQ-028 SHALL discard all FIFO contents and in-flight pipeline data on reset asserted mid-operation; no duty_upd after release until a new pop.
REQ-029 SHALL place the first tick after reset release at the SAMPLE_DIV-th rising edge.

Verification (SAMPLE_DIV = 8, DEPTH = 4)
REQ-030 SHALL cover: reset, then idle -> duty = 16'h8000, smpl_rdy = 1 after release, underrun = 1 after first tick.
REQ-031 SHALL cover: push 16'h4000, volume = 8'h80 -> duty = 16'hA000 with duty_upd pulse 2 cycles after tick.
REQ-032 SHALL cover: push 16'h8000 (-32768), volume = 8'hFF -> scaled = 16'h8080 (-32640), duty = 16'h0080; volume = 0 -> duty = 16'h8000.
REQ-033 SHALL cover: 5 back-to-back pushes, no ticks -> 4 accepted, smpl_rdy = 0, 5th held; next tick pops oldest, smpl_rdy = 1; 4 pops return samples in order.
REQ-034 SHALL cover: tick with empty FIFO and simultaneous push -> underrun = 1, duty held, sample output at next tick; clr_underrun coincident with another empty tick -> underrun stays 1.
REQ-035 SHALL cover: rst_n pulsed low one cycle after a pop -> no duty_upd, duty = 16'h8000, FIFO empty.

Source files
------------

// File: rtl/pdm_duty_feeder_if.sv
// Sample-in / duty-out bundle between the FIR filter, the duty feeder and the PDM modulator.
// The master drives samples and controls, and the slave returns duty, status and ready.
interface pdm_duty_feeder_if;
    logic signed [15:0] smpl_in;
    logic               smpl_vld;
    logic               smpl_rdy;
    logic [7:0]         volume;
    logic               clr_underrun;
    logic [15:0]        duty;
    logic               duty_upd;
    logic               underrun;

    modport master (
        output smpl_in, smpl_vld, volume, clr_underrun,
        input  smpl_rdy, duty, duty_upd, underrun
    );

    modport slave (
        input  smpl_in, smpl_vld, volume, clr_underrun,
        output smpl_rdy, duty, duty_upd, underrun
    );
endinterface

// File: rtl/pdm_duty_feeder.sv
// Generic FIFO, then a sample feeder: FIFO -> volume scale -> offset-binary duty, one pop per divider tick.
// Duty appears 2 cycles after the tick; smpl_rdy deasserts while the FIFO holds DEPTH entries.
module fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdat,
    input  logic         pop,
    output logic [W-1:0] rdat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdat    = mem[rptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (!do_push && do_pop) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdat;
    end
endmodule

module pdm_duty_feeder #(
    parameter int DEPTH      = 4,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    pdm_duty_feeder_if.slave  bus
);
    localparam int             DW       = $clog2(SAMPLE_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(SAMPLE_DIV - 1);

    logic [DW-1:0]      div_cnt;
    logic               tick;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [15:0]        head;
    logic signed [23:0] prod;
    logic [15:0]        scl_q;
    logic               scl_vld;
    logic [15:0]        duty_q;
    logic               upd_q;
    logic               und_q;

    assign tick         = (div_cnt == DIV_LAST);
    assign bus.smpl_rdy = rst_n && !fifo_full;
    assign push         = bus.smpl_vld && bus.smpl_rdy;
    assign pop          = tick && !fifo_empty;

    fifo #(.W(16), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdat  (bus.smpl_in),
        .pop   (pop),
        .rdat  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Volume is zero-extended so 255 stays positive; the product always fits 24 signed bits.
    assign prod = $signed(head) * $signed({1'b0, bus.volume});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            scl_q   <= '0;
            scl_vld <= 1'b0;
            duty_q  <= 16'h8000;
            upd_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            scl_vld <= pop;
            if (pop) scl_q <= 16'(prod >>> 8);
            upd_q <= scl_vld;
            if (scl_vld) duty_q <= scl_q ^ 16'h8000;
            // A fresh underrun outranks a clear arriving in the same cycle.
            if (tick && fifo_empty) und_q <= 1'b1;
            else if (bus.clr_underrun) und_q <= 1'b0;
        end
    end

    assign bus.duty     = duty_q;
    assign bus.duty_upd = upd_q;
    assign bus.underrun = und_q;
endmodule

// File: tb/tb_pdm_duty_feeder.sv
// Randomised and directed bench for pdm_duty_feeder against a queue-based reference model.
module tb_pdm_duty_feeder;
    localparam int DIV = 8;
    localparam int DEP = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pdm_duty_feeder_if bus ();

    pdm_duty_feeder #(.DEPTH(DEP), .SAMPLE_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [15:0] val;
    } upd_t;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] q [$];
    upd_t        pend [$];
    logic [15:0] m_duty;
    bit          m_upd;
    bit          m_und;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [15:0] expect_duty(input logic [15:0] s, input logic [7:0] v);
        int p;
        p = int'($signed(s)) * int'(v);
        p = p >>> 8;
        return p[15:0] ^ 16'h8000;
    endfunction

    // One clock: drive inputs, predict the edge, then compare at the following negedge.
    task automatic step(input bit vld, input logic [15:0] dat, input logic [7:0] vol, input bit clr);
        bit          rdy_m;
        bit          tick;
        logic [15:0] h;
        upd_t        u;
        bus.smpl_vld     = vld;
        bus.smpl_in      = dat;
        bus.volume       = vol;
        bus.clr_underrun = clr;
        rdy_m = (q.size() < DEP);
        tick  = ((cyc % DIV) == DIV - 1);
        m_upd = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            m_duty = pend[0].val;
            m_upd  = 1'b1;
            pend.delete(0);
        end
        if (tick && q.size() == 0) m_und = 1'b1;
        else if (clr) m_und = 1'b0;
        if (tick && q.size() > 0) begin
            h     = q.pop_front();
            u.due = cyc + 2;
            u.val = expect_duty(h, vol);
            pend.push_back(u);
        end
        if (vld && rdy_m) q.push_back(dat);
        cyc++;
        @(posedge clk);
        @(negedge clk);
        chk("smpl_rdy", 32'(bus.smpl_rdy), 32'(q.size() < DEP));
        chk("duty",     32'(bus.duty),     32'(m_duty));
        chk("duty_upd", 32'(bus.duty_upd), 32'(m_upd));
        chk("underrun", 32'(bus.underrun), 32'(m_und));
    endtask

    task automatic do_reset();
        bus.smpl_vld     = 1'b0;
        bus.clr_underrun = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        pend.delete();
        m_duty = 16'h8000;
        m_upd  = 1'b0;
        m_und  = 1'b0;
        cyc    = 0;
        chk("rst_rdy",  32'(bus.smpl_rdy), 32'd0);
        chk("rst_duty", 32'(bus.duty),     32'h8000);
        chk("rst_upd",  32'(bus.duty_upd), 32'd0);
        chk("rst_und",  32'(bus.underrun), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_to_tick(input logic [7:0] vol);
        while ((cyc % DIV) != DIV - 1) step(1'b0, 16'h0, vol, 1'b0);
    endtask

    initial begin
        logic [15:0] s [5];
        logic [15:0] held;
        int          got;
        int          nupd;
        bus.smpl_vld     = 1'b0;
        bus.smpl_in      = 16'h0;
        bus.volume       = 8'h0;
        bus.clr_underrun = 1'b0;
        rst_n = 1'b0;
        cyc   = 0;
        repeat (2) @(negedge clk);
        do_reset();

        // Idle after reset: ready at once, underrun on the 8th edge.
        step(1'b0, 16'h0, 8'h80, 1'b0);
        chk("rdy_after_rst", 32'(bus.smpl_rdy), 32'd1);
        repeat (DIV - 1) step(1'b0, 16'h0, 8'h80, 1'b0);
        chk("und_first_tick", 32'(bus.underrun), 32'd1);
        chk("duty_idle", 32'(bus.duty), 32'h8000);

        // 0x4000 at half volume.
        step(1'b0, 16'h0, 8'h80, 1'b1);
        chk("und_cleared", 32'(bus.underrun), 32'd0);
        step(1'b1, 16'h4000, 8'h80, 1'b0);
        idle_to_tick(8'h80);
        step(1'b0, 16'h0, 8'h80, 1'b0);
        chk("upd_not_early", 32'(bus.duty_upd), 32'd0);
        step(1'b0, 16'h0, 8'h80, 1'b0);
        chk("duty_a000", 32'(bus.duty), 32'hA000);
        chk("upd_a000", 32'(bus.duty_upd), 32'd1);
        step(1'b0, 16'h0, 8'h80, 1'b0);
        chk("upd_one_cycle", 32'(bus.duty_upd), 32'd0);
        chk("duty_held", 32'(bus.duty), 32'hA000);

        // Full-scale negative at 255/256, then muted.
        step(1'b1, 16'h8000, 8'hFF, 1'b0);
        idle_to_tick(8'hFF);
        step(1'b0, 16'h0, 8'hFF, 1'b0);
        step(1'b0, 16'h0, 8'hFF, 1'b0);
        chk("duty_0080", 32'(bus.duty), 32'h0080);
        step(1'b1, 16'h8000, 8'h00, 1'b0);
        idle_to_tick(8'h00);
        step(1'b0, 16'h0, 8'h00, 1'b0);
        step(1'b0, 16'h0, 8'h00, 1'b0);
        chk("duty_mute", 32'(bus.duty), 32'h8000);
        chk("upd_mute", 32'(bus.duty_upd), 32'd1);

        // Five back-to-back pushes starting right after a tick.
        for (int i = 0; i < 5; i++) s[i] = 16'(16'h1100 * (i + 1));
        idle_to_tick(8'hFF);
        step(1'b0, 16'h0, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, s[i], 8'hFF, 1'b0);
        chk("rdy_full", 32'(bus.smpl_rdy), 32'd0);
        while ((cyc % DIV) != DIV - 1) step(1'b1, s[4], 8'hFF, 1'b0);
        step(1'b1, s[4], 8'hFF, 1'b0);
        chk("rdy_after_pop", 32'(bus.smpl_rdy), 32'd1);
        got = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            step(c == 0, s[4], 8'hFF, 1'b0);
            if (bus.duty_upd) begin
                chk($sformatf("order%0d", got), 32'(bus.duty), 32'(expect_duty(s[got], 8'hFF)));
                got++;
            end
        end
        chk("order_count", 32'(got), 32'd5);

        // Empty tick with a simultaneous push.
        idle_to_tick(8'hFF);
        step(1'b0, 16'h0, 8'hFF, 1'b0);
        step(1'b0, 16'h0, 8'hFF, 1'b1);
        chk("und_clr2", 32'(bus.underrun), 32'd0);
        idle_to_tick(8'hFF);
        held = m_duty;
        step(1'b1, 16'h1234, 8'hFF, 1'b0);
        chk("und_push_race", 32'(bus.underrun), 32'd1);
        chk("duty_held_und", 32'(bus.duty), 32'(held));
        idle_to_tick(8'hFF);
        step(1'b0, 16'h0, 8'hFF, 1'b0);
        step(1'b0, 16'h0, 8'hFF, 1'b0);
        chk("duty_late_push", 32'(bus.duty), 32'(expect_duty(16'h1234, 8'hFF)));
        idle_to_tick(8'hFF);
        step(1'b0, 16'h0, 8'hFF, 1'b1);
        chk("und_clr_race", 32'(bus.underrun), 32'd1);
        step(1'b0, 16'h0, 8'hFF, 1'b1);
        chk("und_clr3", 32'(bus.underrun), 32'd0);

        // Reset one cycle after a pop.
        step(1'b1, 16'h7FFF, 8'hFF, 1'b0);
        step(1'b1, 16'h2222, 8'hFF, 1'b0);
        idle_to_tick(8'hFF);
        step(1'b0, 16'h0, 8'hFF, 1'b0);
        do_reset();
        nupd = 0;
        for (int c = 0; c < DIV; c++) begin
            step(1'b0, 16'h0, 8'hFF, 1'b0);
            if (bus.duty_upd) nupd++;
        end
        chk("no_upd_after_rst", 32'(nupd), 32'd0);
        chk("fifo_empty_after_rst", 32'(bus.underrun), 32'd1);
        chk("duty_after_rst", 32'(bus.duty), 32'h8000);

        // Random traffic: a busy phase that fills the FIFO, then a sparse one that starves it.
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 2) == 0, 16'($urandom), 8'($urandom), $urandom_range(0, 15) == 0);
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 11) == 0, 16'($urandom), 8'($urandom), $urandom_range(0, 15) == 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
